// File: rtl/dbus_bridge_if.sv
// CPU data-port bundle between myCPU (master) and the data bus bridge (slave).
interface dbus_bridge_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [31:0] bus_rdata;

  modport master (
    output bus_addr,
    output bus_wdata,
    output bus_we,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr,
    input  bus_wdata,
    input  bus_we,
    output bus_rdata
  );
endinterface

// File: rtl/dbus_bridge.sv
// Data-bus bridge: steers CPU loads/stores to DRAM or to the MMIO registers
// (7-seg data, timer, LEDs, switches). Reads are combinational.
module dbus_bridge #(
  parameter int          DRAM_AW = 14,
  parameter int          SW_W    = 24,
  parameter logic [31:0] IO_BASE = 32'hFFFF_F000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  dbus_bridge_if.slave       bus,
  output logic [DRAM_AW-1:0] dram_a,
  output logic [31:0]        dram_d,
  output logic               dram_we,
  input  logic [31:0]        dram_spo,
  input  logic [SW_W-1:0]    sw_in,
  output logic [SW_W-1:0]    led_out,
  output logic [31:0]        seg_data,
  output logic               timer_irq
);

  // Word offsets inside the 4 KB window (byte offset >> 2).
  localparam logic [9:0] OFF_SEG  = 10'h000;
  localparam logic [9:0] OFF_TCNT = 10'h008;
  localparam logic [9:0] OFF_TDIV = 10'h009;
  localparam logic [9:0] OFF_LED  = 10'h018;
  localparam logic [9:0] OFF_SW   = 10'h01C;

  logic            mmio;
  logic [9:0]      word_off;
  logic            we_seg, we_tcnt, we_tdiv, we_led;
  logic            tick;
  logic            unused_addr_bits;

  logic [31:0]     seg_q,   seg_d;
  logic [SW_W-1:0] led_q,   led_d;
  logic [31:0]     tcnt_q,  tcnt_d;
  logic [31:0]     tdiv_q,  tdiv_d;
  logic [31:0]     pcnt_q,  pcnt_d;
  logic            irq_q,   irq_d;
  logic [SW_W-1:0] sync1_q, sync2_q;
  logic [31:0]     rdata;

  // Byte-lane bits are irrelevant: only whole-word accesses exist.
  assign unused_addr_bits = ^bus.bus_addr[1:0];

  assign mmio     = (bus.bus_addr[31:12] == IO_BASE[31:12]);
  assign word_off = bus.bus_addr[11:2];
  assign we_seg   = bus.bus_we & mmio & (word_off == OFF_SEG);
  assign we_tcnt  = bus.bus_we & mmio & (word_off == OFF_TCNT);
  assign we_tdiv  = bus.bus_we & mmio & (word_off == OFF_TDIV);
  assign we_led   = bus.bus_we & mmio & (word_off == OFF_LED);

  // DRAM sees every address/data; only the strobe is gated by decode,
  // so MMIO stores (including the read-only SW slot) never reach DRAM.
  assign dram_a  = bus.bus_addr[DRAM_AW+1:2];
  assign dram_d  = bus.bus_wdata;
  assign dram_we = bus.bus_we & ~mmio;

  assign tick = (pcnt_q == tdiv_q);

  // Next-state for MMIO registers and timer; CPU writes override counting.
  always_comb begin
    seg_d  = we_seg ? bus.bus_wdata : seg_q;
    led_d  = we_led ? bus.bus_wdata[SW_W-1:0] : led_q;
    tdiv_d = tdiv_q;
    pcnt_d = tick ? 32'd0 : pcnt_q + 32'd1;
    tcnt_d = tick ? tcnt_q + 32'd1 : tcnt_q;
    irq_d  = tick & (tcnt_q == 32'hFFFF_FFFF) & ~we_tcnt;
    if (we_tdiv) begin
      tdiv_d = bus.bus_wdata;
      pcnt_d = 32'd0;
    end
    if (we_tcnt) begin
      tcnt_d = bus.bus_wdata;
      pcnt_d = 32'd0;
    end
  end

  // State registers and two-flop switch synchroniser, async active-low reset.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      seg_q   <= '0;
      led_q   <= '0;
      tcnt_q  <= '0;
      tdiv_q  <= '0;
      pcnt_q  <= '0;
      irq_q   <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      seg_q   <= seg_d;
      led_q   <= led_d;
      tcnt_q  <= tcnt_d;
      tdiv_q  <= tdiv_d;
      pcnt_q  <= pcnt_d;
      irq_q   <= irq_d;
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

  // Combinational load-data mux; unmapped MMIO offsets read as zero.
  always_comb begin
    rdata = 32'd0;
    if (!mmio) begin
      rdata = dram_spo;
    end else begin
      case (word_off)
        OFF_SEG:  rdata = seg_q;
        OFF_TCNT: rdata = tcnt_q;
        OFF_TDIV: rdata = tdiv_q;
        OFF_LED:  rdata = {{(32-SW_W){1'b0}}, led_q};
        OFF_SW:   rdata = {{(32-SW_W){1'b0}}, sync2_q};
        default:  rdata = 32'd0;
      endcase
    end
  end

  assign bus.bus_rdata = rdata;
  assign led_out       = led_q;
  assign seg_data      = seg_q;
  assign timer_irq     = irq_q;

endmodule

// File: tb/tb_dbus_bridge.sv
module tb_dbus_bridge;

  localparam logic [31:0] A_SEG  = 32'hFFFF_F000;
  localparam logic [31:0] A_TCNT = 32'hFFFF_F020;
  localparam logic [31:0] A_TDIV = 32'hFFFF_F024;
  localparam logic [31:0] A_LED  = 32'hFFFF_F060;
  localparam logic [31:0] A_SW   = 32'hFFFF_F070;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [13:0] dram_a;
  logic [31:0] dram_d;
  logic        dram_we;
  logic [31:0] dram_spo;
  logic [23:0] sw_in;
  logic [23:0] led_out;
  logic [31:0] seg_data;
  logic        timer_irq;

  int errs   = 0;
  int checks = 0;

  dbus_bridge_if bus_if ();

  dbus_bridge #(
    .DRAM_AW (14),
    .SW_W    (24),
    .IO_BASE (32'hFFFF_F000)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .bus       (bus_if.slave),
    .dram_a    (dram_a),
    .dram_d    (dram_d),
    .dram_we   (dram_we),
    .dram_spo  (dram_spo),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .seg_data  (seg_data),
    .timer_irq (timer_irq)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Stimulus helper: one store cycle, returns 1ns after the storing edge.
  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    bus_if.bus_we    = 1'b1;
    @(posedge cpu_clk); #1;
    bus_if.bus_we    = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge cpu_clk); #1;
    write_word(A_LED, 32'h0012_3456);
    write_word(A_SEG, 32'hCAFE_0001);
    checks++;
    if (led_out !== 24'h12_3456) begin
      errs++; $display("FAIL pre_reset_led: got %h want %h", led_out, 24'h12_3456);
    end
    #2 cpu_rst = 1'b0;
    #1;
    checks++;
    if (led_out !== 24'h0) begin
      errs++; $display("FAIL reset_led: got %h want 0", led_out);
    end
    checks++;
    if (seg_data !== 32'h0) begin
      errs++; $display("FAIL reset_seg: got %h want 0", seg_data);
    end
    checks++;
    if (timer_irq !== 1'b0) begin
      errs++; $display("FAIL reset_irq: got %b want 0", timer_irq);
    end
    bus_if.bus_addr = 32'h0000_0100;
    bus_if.bus_we   = 1'b1;
    #1;
    checks++;
    if (dram_we !== 1'b1) begin
      errs++; $display("FAIL reset_dram_we: got %b want 1", dram_we);
    end
    bus_if.bus_we = 1'b0;
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b1;
    bus_if.bus_addr = A_TCNT;
    #1;
    checks++;
    if (bus_if.bus_rdata !== 32'h0) begin
      errs++; $display("FAIL reset_tcnt: got %h want 0", bus_if.bus_rdata);
    end
    @(posedge cpu_clk); #1;
    checks++;
    if (bus_if.bus_rdata !== 32'h1) begin
      errs++; $display("FAIL resume_tcnt: got %h want 1", bus_if.bus_rdata);
    end
  endtask

  task automatic test_dram;
    bus_if.bus_addr  = 32'h0000_0100;
    bus_if.bus_wdata = 32'hDEAD_BEEF;
    bus_if.bus_we    = 1'b1;
    #1;
    checks++;
    if (dram_we !== 1'b1) begin
      errs++; $display("FAIL dram_we: got %b want 1", dram_we);
    end
    checks++;
    if (dram_a !== 14'h040) begin
      errs++; $display("FAIL dram_a: got %h want 040", dram_a);
    end
    checks++;
    if (dram_d !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL dram_d: got %h want deadbeef", dram_d);
    end
    @(posedge cpu_clk); #1;
    bus_if.bus_we = 1'b0;
    dram_spo = 32'h0000_1234;
    #1;
    checks++;
    if (bus_if.bus_rdata !== 32'h0000_1234) begin
      errs++; $display("FAIL dram_read: got %h want 1234", bus_if.bus_rdata);
    end
  endtask

  task automatic test_mmio;
    dram_spo = 32'h5555_5555;
    bus_if.bus_addr  = A_LED;
    bus_if.bus_wdata = 32'h00A5_A5A5;
    bus_if.bus_we    = 1'b1;
    #1;
    checks++;
    if (dram_we !== 1'b0) begin
      errs++; $display("FAIL led_store_dram_we: got %b want 0", dram_we);
    end
    @(posedge cpu_clk); #1;
    bus_if.bus_we = 1'b0;
    checks++;
    if (led_out !== 24'hA5_A5A5) begin
      errs++; $display("FAIL led_out: got %h want a5a5a5", led_out);
    end
    checks++;
    if (bus_if.bus_rdata !== 32'h00A5_A5A5) begin
      errs++; $display("FAIL led_read: got %h want 00a5a5a5", bus_if.bus_rdata);
    end
    bus_if.bus_addr  = A_SW;
    bus_if.bus_wdata = 32'h0000_0123;
    bus_if.bus_we    = 1'b1;
    #1;
    checks++;
    if (dram_we !== 1'b0) begin
      errs++; $display("FAIL sw_store_dram_we: got %b want 0", dram_we);
    end
    @(posedge cpu_clk); #1;
    bus_if.bus_we = 1'b0;
    checks++;
    if (led_out !== 24'hA5_A5A5) begin
      errs++; $display("FAIL sw_store_led: got %h want a5a5a5", led_out);
    end
    checks++;
    if (bus_if.bus_rdata !== 32'h0) begin
      errs++; $display("FAIL sw_store_read: got %h want 0", bus_if.bus_rdata);
    end
    bus_if.bus_addr = 32'hFFFF_F063;
    #1;
    checks++;
    if (bus_if.bus_rdata !== 32'h00A5_A5A5) begin
      errs++; $display("FAIL led_unaligned_read: got %h want 00a5a5a5", bus_if.bus_rdata);
    end
    bus_if.bus_addr = 32'hFFFF_F040;
    #1;
    checks++;
    if (bus_if.bus_rdata !== 32'h0) begin
      errs++; $display("FAIL unmapped_read: got %h want 0", bus_if.bus_rdata);
    end
    write_word(A_SEG, 32'h1357_9BDF);
    checks++;
    if (seg_data !== 32'h1357_9BDF) begin
      errs++; $display("FAIL seg_data: got %h want 13579bdf", seg_data);
    end
    checks++;
    if (bus_if.bus_rdata !== 32'h1357_9BDF) begin
      errs++; $display("FAIL seg_read: got %h want 13579bdf", bus_if.bus_rdata);
    end
  endtask

  task automatic test_switch;
    sw_in = 24'h00_F00F;
    bus_if.bus_addr = A_SW;
    #1;
    checks++;
    if (bus_if.bus_rdata !== 32'h0) begin
      errs++; $display("FAIL sw_edge0: got %h want 0", bus_if.bus_rdata);
    end
    @(posedge cpu_clk); #1;
    checks++;
    if (bus_if.bus_rdata !== 32'h0) begin
      errs++; $display("FAIL sw_edge1: got %h want 0", bus_if.bus_rdata);
    end
    @(posedge cpu_clk); #1;
    checks++;
    if (bus_if.bus_rdata !== 32'h0000_F00F) begin
      errs++; $display("FAIL sw_edge2: got %h want 0000f00f", bus_if.bus_rdata);
    end
  endtask

  task automatic test_prescale;
    write_word(A_TDIV, 32'd3);
    checks++;
    if (bus_if.bus_rdata !== 32'd3) begin
      errs++; $display("FAIL tdiv_read: got %h want 3", bus_if.bus_rdata);
    end
    write_word(A_TCNT, 32'd0);
    repeat (4) @(posedge cpu_clk);
    #1;
    checks++;
    if (bus_if.bus_rdata !== 32'd1) begin
      errs++; $display("FAIL prescale_4: got %h want 1", bus_if.bus_rdata);
    end
    repeat (16) @(posedge cpu_clk);
    #1;
    checks++;
    if (bus_if.bus_rdata !== 32'd5) begin
      errs++; $display("FAIL prescale_20: got %h want 5", bus_if.bus_rdata);
    end
  endtask

  task automatic test_wrap;
    int pulses;
    int at;
    pulses = 0;
    at = 0;
    write_word(A_TDIV, 32'd0);
    write_word(A_TCNT, 32'hFFFF_FFFE);
    checks++;
    if (timer_irq !== 1'b0) begin
      errs++; $display("FAIL wrap_irq_early: got %b want 0", timer_irq);
    end
    for (int i = 1; i <= 5; i++) begin
      @(posedge cpu_clk); #1;
      if (timer_irq === 1'b1) begin
        pulses++;
        at = i;
      end
      if (i == 2) begin
        checks++;
        if (bus_if.bus_rdata !== 32'h0) begin
          errs++; $display("FAIL wrap_tcnt: got %h want 0", bus_if.bus_rdata);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errs++; $display("FAIL wrap_pulse_count: got %0d want 1", pulses);
    end
    checks++;
    if (at !== 2) begin
      errs++; $display("FAIL wrap_pulse_cycle: got %0d want 2", at);
    end
  endtask

  task automatic test_collision;
    write_word(A_TCNT, 32'hFFFF_FFFE);
    @(posedge cpu_clk); #1;
    checks++;
    if (bus_if.bus_rdata !== 32'hFFFF_FFFF) begin
      errs++; $display("FAIL coll_pre: got %h want ffffffff", bus_if.bus_rdata);
    end
    write_word(A_TCNT, 32'd7);
    checks++;
    if (timer_irq !== 1'b0) begin
      errs++; $display("FAIL coll_irq: got %b want 0", timer_irq);
    end
    checks++;
    if (bus_if.bus_rdata !== 32'd7) begin
      errs++; $display("FAIL coll_tcnt: got %h want 7", bus_if.bus_rdata);
    end
    @(posedge cpu_clk); #1;
    checks++;
    if (timer_irq !== 1'b0) begin
      errs++; $display("FAIL coll_irq_after: got %b want 0", timer_irq);
    end
    checks++;
    if (bus_if.bus_rdata !== 32'd8) begin
      errs++; $display("FAIL coll_tcnt_after: got %h want 8", bus_if.bus_rdata);
    end
  endtask

  initial begin
    cpu_rst          = 1'b1;
    bus_if.bus_addr  = 32'h0;
    bus_if.bus_wdata = 32'h0;
    bus_if.bus_we    = 1'b0;
    dram_spo         = 32'h0;
    sw_in            = 24'h0;
    test_reset();
    test_dram();
    test_mmio();
    test_switch();
    test_prescale();
    test_wrap();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dbus_bridge.md
Name: dbus_bridge

Overview:
Responder on the CPU data-memory port. It decodes each CPU load/store address and steers the access either to DRAM or to a small set of memory-mapped peripherals: switches, LEDs, a 7-segment data register and a free-running timer. It sits between myCPU's data interface and DRAM inside miniRV_SoC, so peripheral addresses never reach DRAM.

Parameters:
DRAM_AW, 14, DRAM word-address width passed to DRAM.a
SW_W, 24, switch and LED width
IO_BASE, 32'hFFFF_F000, base of the 4 KB MMIO window

Ports:
cpu_clk  in  1  system clock, all state on rising edge
cpu_rst  in  1  asynchronous reset, active-low
bus_addr  in  32  CPU byte address (ALU result)
bus_wdata  in  32  store data
bus_we  in  1  store strobe, one cycle per store
bus_rdata  out  32  load data, combinational from the addressed target
dram_a  out  DRAM_AW  DRAM address, bus_addr[DRAM_AW+1:2]
dram_d  out  32  DRAM write data, equal to bus_wdata
dram_we  out  1  DRAM write enable, gated by decode
dram_spo  in  32  DRAM read data
sw_in  in  SW_W  raw, asynchronous switch pins
led_out  out  SW_W  LED register
seg_data  out  32  7-segment display data register
timer_irq  out  1  one-cycle pulse when the timer wraps

Behaviour:
- Decode: MMIO when bus_addr[31:12] == IO_BASE[31:12]; otherwise DRAM.
- MMIO offsets use bus_addr[11:0]:
  - 0x000 SEG (RW)
  - 0x020 TCNT (RW)
  - 0x024 TDIV (RW)
  - 0x060 LED (RW)
  - 0x070 SW (RO)
- Unmapped MMIO offsets read 0. Writes to them are ignored.
- dram_we = bus_we & ~mmio. dram_a and dram_d are always driven.
- bus_rdata is dram_spo for DRAM addresses, otherwise the selected register, zero-extended to 32 bits. There is no read latency; the single-cycle CPU requires a combinational read.
- Stores take effect on the rising edge where bus_we=1. A load in the following cycle returns the new value.
- Switch sync: two flops sync1→sync2 on sw_in. SW reads return sync2, so latency from a pin change to a visible read is 2 edges.
- Timer:
  - 32-bit prescaler pcnt and 32-bit counter TCNT.
  - Each cycle: if pcnt == TDIV, then pcnt←0 and TCNT←TCNT+1; else pcnt←pcnt+1.
  - TDIV=0 makes TCNT increment every cycle.
  - Wrap: TCNT 0xFFFF_FFFF→0 in the same increment. timer_irq=1 for exactly that cycle (registered, asserted the cycle after the wrapping edge).
- Writes to the timer:
  - Writing TCNT loads bus_wdata and clears pcnt. The write wins over a same-cycle increment.
  - Writing TDIV loads the value and clears pcnt.
  - A write to TCNT in the wrap cycle suppresses timer_irq.
- Reset (cpu_rst=0, async): SEG=0, LED=0, TCNT=0, TDIV=0, pcnt=0, sync flops=0, timer_irq=0.
  - A reset mid-count discards all timer state. Counting resumes on the first edge after release.
  - bus_rdata and dram_we stay combinational during reset; dram_we follows the decode.
- SW is read-only: a store to SW is dropped and does not reach DRAM.
- Only 32-bit word accesses are supported. bus_addr[1:0] is ignored in both the DRAM and MMIO paths.

Test Plan:
- Reset then idle: drive cpu_rst=0 mid-cycle → led_out=0, seg_data=0, timer_irq=0 immediately (async); TCNT reads 0 after release.
- DRAM passthrough: store 0xDEADBEEF to 0x0000_0100 → dram_we=1, dram_a=0x040, dram_d=0xDEADBEEF. A load from 0x0000_0100 with dram_spo=0x1234 → bus_rdata=0x1234.
- MMIO store isolation: store 0x00A5A5A5 to 0xFFFF_F060 → dram_we=0, led_out=0x00A5A5A5 after the edge, and a readback matches. A store to 0xFFFF_F070 leaves both DRAM and LED unchanged.
- Switch sync: sw_in 0→0x00F00F → an SW read is still 0 after 1 edge and equals 0x00F00F after 2 edges.
- Timer prescale: write TDIV=3, then TCNT=0 → TCNT reads 1 after 4 cycles and 5 after 20 cycles.
- Wrap and collision:
  - TDIV=0, TCNT=0xFFFF_FFFE → timer_irq pulses exactly once, 2 cycles later, and TCNT=0.
  - Repeat, but write TCNT=7 in the wrap cycle → no pulse, TCNT=7.
